mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive LS grants allowed while IF waits.
REQ-002 SHALL have one clock and a synchronous, active-high reset, as fixed below.
  - clk_in  in  1  system clock.
  - rst_in  in  1  synchronous active-high reset.
  - rdy_in  in  1  global enable; low freezes all state.
  - clear  in  1  pipeline flush, qualified by rdy_in.
  - io_buffer_full  in  1  UART buffer full; blocks issue.
  - if_req, if_addr  in  1/32  instruction fetch request and address.
  - if_done, if_data, if_is_c  out  1/32/1  fetch done pulse, instruction, compressed flag.
  - ls_req, ls_addr, ls_wdata, ls_type  in  1/32/32/4  load/store request; ls_type is {store, signed-n, size[1:0]}.
  - ls_done, ls_rdata  out  1/32  load/store done pulse, load result.
  - pf_req, pf_addr  in  1/32  prefetch request and address.
  - pf_done, pf_data  out  1/32  prefetch done pulse, fetched word.
  - mc_if_enable, mc_inst_addr  out  1/32  fetch issue to the memory controller.
  - mc_ls_enable, mc_ls_addr, mc_store_val, mc_lsb_type  out  1/32/32/4  load/store issue to the memory controller.
  - mc_if_ready, mc_inst, mc_is_c  in  1/32/1  controller fetch completion.
  - mc_ls_finished, mc_load_val  in  1/32  controller load/store completion.
  - arb_busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement the states IDLE, ISSUE, WAIT and RESP, and SHALL register all outputs.
REQ-004 SHALL, in IDLE with any request high, latch the winner, its operands and its source tag (IF/LS/PF), then go to ISSUE on the next cycle.
REQ-005 SHALL use fixed priority LS > IF > PF, except the starvation rule in REQ-006.
REQ-006 SHALL maintain a 3-bit counter with these rules:
  - increment on each LS grant made while if_req is high;
  - clear on an IF grant, and on any arbitration where if_req is low;
  - when the counter equals STARVE_LIMIT and if_req is high, grant IF ahead of LS;
  - saturate; never wrap.
REQ-007 SHALL, in ISSUE, drive exactly one of mc_if_enable or mc_ls_enable high, with the latched operands; PF uses the IF path.
REQ-008 SHALL keep driving the enable while io_buffer_full=1, and SHALL go to WAIT in the first ISSUE cycle with io_buffer_full=0.
REQ-009 SHALL drop the enable in WAIT, so that each grant produces exactly one controller transaction.
REQ-010 SHALL, in WAIT, react to the completion signal matching the source tag as follows:
  - IF tag and mc_if_ready: capture mc_inst and mc_is_c;
  - PF tag and mc_if_ready: capture mc_inst;
  - LS tag and mc_ls_finished: capture mc_load_val;
  - in each case, go to RESP.
REQ-011 SHALL ignore a completion signal whose path does not match the tag, and any completion signal outside WAIT.
REQ-012 SHALL, in RESP, assert for exactly one cycle the done pulse of the granted requester only, with its data valid in that cycle, then go to IDLE.
REQ-013 SHALL never assert two done pulses, or both mc enables, in the same cycle.
REQ-014 SHALL hold if_data, ls_rdata and pf_data at their last captured values between completions.
REQ-015 SHALL give a minimum latency of 4 cycles from a request sampled in IDLE to its done pulse, plus the controller's transaction time.
REQ-016 SHALL require each requester to hold req and operands stable until it sees done, and to deassert req in the following cycle; operand changes while granted are ignored.
REQ-017 SHALL treat a request dropped before it is granted as withdrawn, with no transaction.
REQ-018 SHALL, when rdy_in=1 and clear=1 in any state, go to IDLE, clear both enables, all done pulses and the starvation counter, and emit no done for the aborted transaction.
REQ-019 SHALL, when rdy_in=0, hold all state and outputs, and SHALL ignore clear, requests and completions.

Reset
REQ-020 SHALL, on rst_in=1 at a clock edge, regardless of rdy_in, set the following:
  - state to IDLE and the counter to 0;
  - every output to 0, including all data, address and type outputs.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Simultaneous arbitration: ls_req=if_req=pf_req=1 in IDLE -> LS is issued first (mc_ls_enable=1, mc_ls_addr=ls_addr); after mc_ls_finished with mc_load_val=0x12345678, ls_done=1 for one cycle and ls_rdata=0x12345678.
  - Starvation: if_req held high with ls_req re-raised after every completion, STARVE_LIMIT=4 -> exactly 4 LS grants, then the 5th grant is IF (mc_if_enable=1).
  - UART backpressure: io_buffer_full=1 for 3 cycles during ISSUE -> the enable stays high 4 cycles and WAIT is entered on the cycle io_buffer_full falls.
  - Compressed fetch: IF grant, mc_if_ready=1, mc_is_c=1, mc_inst=0x00004501 -> if_done=1, if_is_c=1, if_data=0x00004501; pf_done and ls_done stay 0.
  - Flush in flight: clear=1 in WAIT with an LS grant, then mc_ls_finished=1 -> no ls_done, state IDLE, arb_busy=0 the cycle after clear.
  - Freeze: rdy_in=0 for 5 cycles during WAIT with mc_if_ready pulsing -> state and outputs unchanged; completion taken only after rdy_in returns high.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates LS/IF/PF requests onto one memory controller, one transaction per grant.
// Ports: clk_in/rst_in clock and sync reset; rdy_in global enable; clear flush;
//   io_buffer_full blocks issue; if_*/ls_*/pf_* requester request and done sides;
//   mc_* controller issue and completion; arb_busy high outside IDLE.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  output logic        if_is_c,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_type,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_data,
  output logic        mc_if_enable,
  output logic [31:0] mc_inst_addr,
  output logic        mc_ls_enable,
  output logic [31:0] mc_ls_addr,
  output logic [31:0] mc_store_val,
  output logic [3:0]  mc_lsb_type,
  input  logic        mc_if_ready,
  input  logic [31:0] mc_inst,
  input  logic        mc_is_c,
  input  logic        mc_ls_finished,
  input  logic [31:0] mc_load_val,
  output logic        arb_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_IF, SRC_LS, SRC_PF} src_t;
  state_t state_q, state_d;
  src_t src_q, src_d;
  logic [2:0] cnt_q, cnt_d;
  logic if_done_q, if_done_d, if_is_c_q, if_is_c_d, ls_done_q, ls_done_d, pf_done_q, pf_done_d;
  logic [31:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d, pf_data_q, pf_data_d;
  logic mc_if_enable_q, mc_if_enable_d, mc_ls_enable_q, mc_ls_enable_d, arb_busy_q, arb_busy_d;
  logic [31:0] mc_inst_addr_q, mc_inst_addr_d, mc_ls_addr_q, mc_ls_addr_d, mc_store_val_q, mc_store_val_d;
  logic [3:0] mc_lsb_type_q, mc_lsb_type_d;
  logic starved, grant_if, grant_ls;
  // IF overtakes LS once LS has won STARVE_LIMIT arbitrations in a row against a waiting IF
  assign starved  = if_req && cnt_q == 3'(STARVE_LIMIT);
  assign grant_if = if_req && (!ls_req || starved);
  assign grant_ls = ls_req && !grant_if;
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    if_done_d      = if_done_q;
    if_data_d      = if_data_q;
    if_is_c_d      = if_is_c_q;
    ls_done_d      = ls_done_q;
    ls_rdata_d     = ls_rdata_q;
    pf_done_d      = pf_done_q;
    pf_data_d      = pf_data_q;
    mc_if_enable_d = mc_if_enable_q;
    mc_inst_addr_d = mc_inst_addr_q;
    mc_ls_enable_d = mc_ls_enable_q;
    mc_ls_addr_d   = mc_ls_addr_q;
    mc_store_val_d = mc_store_val_q;
    mc_lsb_type_d  = mc_lsb_type_q;
    if (rdy_in) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      pf_done_d = 1'b0;
      if (clear) begin
        state_d        = IDLE;
        cnt_d          = 3'd0;
        mc_if_enable_d = 1'b0;
        mc_ls_enable_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: if (if_req || ls_req || pf_req) begin
            state_d        = ISSUE;
            src_d          = grant_ls ? SRC_LS : grant_if ? SRC_IF : SRC_PF;
            cnt_d          = (!if_req || grant_if) ? 3'd0 : cnt_q == 3'd7 ? cnt_q : cnt_q + 3'd1;
            mc_if_enable_d = !grant_ls;
            mc_ls_enable_d = grant_ls;
            mc_inst_addr_d = grant_ls ? mc_inst_addr_q : grant_if ? if_addr : pf_addr;
            mc_ls_addr_d   = grant_ls ? ls_addr : mc_ls_addr_q;
            mc_store_val_d = grant_ls ? ls_wdata : mc_store_val_q;
            mc_lsb_type_d  = grant_ls ? ls_type : mc_lsb_type_q;
          end
          ISSUE: if (!io_buffer_full) begin
            state_d        = WAIT;
            mc_if_enable_d = 1'b0;
            mc_ls_enable_d = 1'b0;
          end
          WAIT: begin
            if (src_q == SRC_IF && mc_if_ready) begin
              if_data_d = mc_inst;
              if_is_c_d = mc_is_c;
              if_done_d = 1'b1;
              state_d   = RESP;
            end
            if (src_q == SRC_PF && mc_if_ready) begin
              pf_data_d = mc_inst;
              pf_done_d = 1'b1;
              state_d   = RESP;
            end
            if (src_q == SRC_LS && mc_ls_finished) begin
              ls_rdata_d = mc_load_val;
              ls_done_d  = 1'b1;
              state_d    = RESP;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    arb_busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      src_q          <= SRC_IF;
      cnt_q          <= '0;
      if_done_q      <= 1'b0;
      if_data_q      <= '0;
      if_is_c_q      <= 1'b0;
      ls_done_q      <= 1'b0;
      ls_rdata_q     <= '0;
      pf_done_q      <= 1'b0;
      pf_data_q      <= '0;
      mc_if_enable_q <= 1'b0;
      mc_inst_addr_q <= '0;
      mc_ls_enable_q <= 1'b0;
      mc_ls_addr_q   <= '0;
      mc_store_val_q <= '0;
      mc_lsb_type_q  <= '0;
      arb_busy_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      cnt_q          <= cnt_d;
      if_done_q      <= if_done_d;
      if_data_q      <= if_data_d;
      if_is_c_q      <= if_is_c_d;
      ls_done_q      <= ls_done_d;
      ls_rdata_q     <= ls_rdata_d;
      pf_done_q      <= pf_done_d;
      pf_data_q      <= pf_data_d;
      mc_if_enable_q <= mc_if_enable_d;
      mc_inst_addr_q <= mc_inst_addr_d;
      mc_ls_enable_q <= mc_ls_enable_d;
      mc_ls_addr_q   <= mc_ls_addr_d;
      mc_store_val_q <= mc_store_val_d;
      mc_lsb_type_q  <= mc_lsb_type_d;
      arb_busy_q     <= arb_busy_d;
    end
  end
  assign if_done      = if_done_q;
  assign if_data      = if_data_q;
  assign if_is_c      = if_is_c_q;
  assign ls_done      = ls_done_q;
  assign ls_rdata     = ls_rdata_q;
  assign pf_done      = pf_done_q;
  assign pf_data      = pf_data_q;
  assign mc_if_enable = mc_if_enable_q;
  assign mc_inst_addr = mc_inst_addr_q;
  assign mc_ls_enable = mc_ls_enable_q;
  assign mc_ls_addr   = mc_ls_addr_q;
  assign mc_store_val = mc_store_val_q;
  assign mc_lsb_type  = mc_lsb_type_q;
  assign arb_busy     = arb_busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with directed scenarios and random traffic.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int K_IF = 0, K_LS = 1, K_PF = 2;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear, io_buffer_full;
  logic if_req, ls_req, pf_req, mc_if_ready, mc_is_c, mc_ls_finished;
  logic [31:0] if_addr, ls_addr, ls_wdata, pf_addr, mc_inst, mc_load_val;
  logic [3:0] ls_type;
  logic if_done, if_is_c, ls_done, pf_done, mc_if_enable, mc_ls_enable, arb_busy;
  logic [31:0] if_data, ls_rdata, pf_data, mc_inst_addr, mc_ls_addr, mc_store_val;
  logic [3:0] mc_lsb_type;
  int checks = 0, errs = 0, m_cnt = 0;
  typedef struct {int kind; logic [31:0] data; logic is_c;} exp_t;
  exp_t exp_q[$];
  logic [31:0] last_data [3];
  always #5 clk_in = ~clk_in;
  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data), .if_is_c(if_is_c),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_type(ls_type),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_data(pf_data),
    .mc_if_enable(mc_if_enable), .mc_inst_addr(mc_inst_addr),
    .mc_ls_enable(mc_ls_enable), .mc_ls_addr(mc_ls_addr), .mc_store_val(mc_store_val), .mc_lsb_type(mc_lsb_type),
    .mc_if_ready(mc_if_ready), .mc_inst(mc_inst), .mc_is_c(mc_is_c),
    .mc_ls_finished(mc_ls_finished), .mc_load_val(mc_load_val), .arb_busy(arb_busy)
  );
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic set_cmp(input int k, input bit on, input logic [31:0] d, input bit c);
    if (k == K_LS) begin
      mc_ls_finished = on;
      mc_load_val    = d;
    end else begin
      mc_if_ready = on;
      mc_inst     = d;
      mc_is_c     = c;
    end
  endtask
  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk_in) begin
    exp_t e;
    int n, k;
    logic [31:0] act;
    if (!rst_in) begin
      if (mc_if_enable || mc_ls_enable) chk("one_enable", {mc_if_enable, mc_ls_enable} == 2'b11, 0);
      n = int'(if_done) + int'(ls_done) + int'(pf_done);
      if (n > 0) begin
        k = if_done ? K_IF : ls_done ? K_LS : K_PF;
        act = k == K_IF ? if_data : k == K_LS ? ls_rdata : pf_data;
        if (n > 1) chk("single_done", n, 1);
        else if (exp_q.size() == 0) chk("unexpected_done", k, -1);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", {k, act, (k == K_IF) ? if_is_c : 1'b0},
              {e.kind, e.data, (e.kind == K_IF) ? e.is_c : 1'b0});
          chk("data_hold", {k == K_IF ? 32'h0 : if_data, k == K_LS ? 32'h0 : ls_rdata, k == K_PF ? 32'h0 : pf_data},
              {k == K_IF ? 32'h0 : last_data[0], k == K_LS ? 32'h0 : last_data[1], k == K_PF ? 32'h0 : last_data[2]});
          last_data[e.kind] = e.data;
        end
      end
    end
  end
  task automatic do_txn(input bit i, input bit l, input bit p, input logic [31:0] ia, input logic [31:0] la,
                        input logic [31:0] wd, input logic [31:0] pa, input logic [3:0] lt,
                        input logic [31:0] rd, input bit isc, input int full, input int dly, input int frz,
                        input bit flush, input bit keep, output int got);
    int w, en_cycles, mk;
    bit seen;
    exp_t e;
    if (pa == ia) pa = pa ^ 32'h4;
    w = (i && l && m_cnt == LIMIT) ? K_IF : l ? K_LS : i ? K_IF : K_PF;
    m_cnt = (!i || w == K_IF) ? 0 : (m_cnt < 7 ? m_cnt + 1 : 7);
    mk = w == K_LS ? K_IF : K_LS;
    @(posedge clk_in); #1;
    if_req = i; ls_req = l; pf_req = p;
    if_addr = ia; ls_addr = la; ls_wdata = wd; pf_addr = pa; ls_type = lt;
    if (!flush) begin
      e.kind = w; e.data = rd; e.is_c = isc;
      exp_q.push_back(e);
    end
    got = -1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk_in); #1;
      seen = mc_if_enable || mc_ls_enable;
    end
    if (!seen) begin
      chk("grant_timeout", 0, 1);
      exp_q.delete();
      if_req = 0; ls_req = 0; pf_req = 0;
      return;
    end
    got = mc_ls_enable ? K_LS : mc_inst_addr == ia ? K_IF : mc_inst_addr == pa ? K_PF : -1;
    chk("winner", got, w);
    if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom; pf_addr = $urandom; ls_type = 4'($urandom);
    en_cycles = 1;
    io_buffer_full = full > 0;
    set_cmp(w, full > 0, ~rd, !isc);
    for (int c = 0; c < full; c++) begin
      @(posedge clk_in); #1;
      en_cycles += int'(mc_if_enable || mc_ls_enable);
    end
    io_buffer_full = 0;
    set_cmp(w, 0, 32'h0, 1'b0);
    @(posedge clk_in); #1;
    chk("issue_cycles", en_cycles, full + 1);
    chk("wait_entry", {arb_busy, mc_if_enable, mc_ls_enable}, 3'b100);
    if (w == K_LS) chk("ls_ops", {mc_ls_addr, mc_store_val, mc_lsb_type}, {la, wd, lt});
    else chk("if_addr", mc_inst_addr, w == K_IF ? ia : pa);
    if (flush) begin
      clear = 1; if_req = 0; ls_req = 0; pf_req = 0;
      @(posedge clk_in); #1;
      clear = 0;
      chk("flush_idle", {arb_busy, mc_if_enable, mc_ls_enable, if_done, ls_done, pf_done}, 0);
      set_cmp(w, 1, rd, isc);
      @(posedge clk_in); #1;
      set_cmp(w, 0, 32'h0, 1'b0);
      chk("flush_no_done", {arb_busy, if_done, ls_done, pf_done}, 0);
      @(posedge clk_in); #1;
      chk("flush_quiet", {arb_busy, if_done, ls_done, pf_done}, 0);
      m_cnt = 0;
      return;
    end
    if (frz > 0) begin
      rdy_in = 0; clear = 1;
      for (int c = 0; c < frz; c++) begin
        set_cmp(w, c % 2 == 0, ~rd, !isc);
        @(posedge clk_in); #1;
        chk("freeze", {arb_busy, mc_if_enable, mc_ls_enable, if_done, ls_done, pf_done, if_data, ls_rdata, pf_data},
            {6'b100000, last_data[0], last_data[1], last_data[2]});
      end
      rdy_in = 1; clear = 0;
      set_cmp(w, 0, 32'h0, 1'b0);
    end
    for (int c = 0; c < dly; c++) begin
      set_cmp(mk, 1, ~rd, 1'b1);
      @(posedge clk_in); #1;
      set_cmp(mk, 0, 32'h0, 1'b0);
    end
    set_cmp(w, 1, rd, isc);
    @(posedge clk_in); #1;
    set_cmp(w, 0, 32'h0, 1'b0);
    chk("done_pulse", {if_done, ls_done, pf_done}, w == K_IF ? 3'b100 : w == K_LS ? 3'b010 : 3'b001);
    if (!keep) begin
      @(posedge clk_in); #1;
      if_req = 0; ls_req = 0; pf_req = 0;
      chk("done_once", {if_done, ls_done, pf_done, arb_busy}, 0);
    end
  endtask
  initial begin
    int got;
    bit i, l, p, fl;
    last_data[0] = 0; last_data[1] = 0; last_data[2] = 0;
    rst_in = 1; rdy_in = 0; clear = 0; io_buffer_full = 0;
    if_req = 1; ls_req = 1; pf_req = 1;
    if_addr = 32'h11; ls_addr = 32'h22; ls_wdata = 32'h33; pf_addr = 32'h44; ls_type = 4'hf;
    mc_if_ready = 0; mc_inst = 0; mc_is_c = 0; mc_ls_finished = 0; mc_load_val = 0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 0; rdy_in = 1; if_req = 0; ls_req = 0; pf_req = 0;
    chk("reset_outputs", {if_done, if_data, if_is_c, ls_done, ls_rdata, pf_done, pf_data, mc_if_enable,
                          mc_inst_addr, mc_ls_enable, mc_ls_addr, mc_store_val, mc_lsb_type, arb_busy}, 0);
    @(posedge clk_in); #1;
    chk("idle_after_reset", {arb_busy, mc_if_enable, mc_ls_enable}, 0);
    do_txn(1, 1, 1, 32'h100, 32'h2000, 32'hdeadbeef, 32'h300, 4'b1010, 32'h12345678, 0, 0, 1, 0, 0, 0, got);
    chk("simul_ls_first", got, K_LS);
    chk("simul_rdata", ls_rdata, 32'h12345678);
    @(posedge clk_in); #1;
    clear = 1;
    @(posedge clk_in); #1;
    clear = 0;
    m_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      do_txn(1, 1, 0, 32'h4000 + 32'(k), $urandom, $urandom, 32'h8000, 4'b0010, $urandom, 0, 0, 0, 0, 0, k < 4, got);
      chk("starve_grant", got, k < 4 ? K_LS : K_IF);
    end
    do_txn(0, 1, 0, 32'h0, 32'h5000, 32'h55aa55aa, 32'h10, 4'b1001, 32'hcafef00d, 0, 3, 0, 0, 0, 0, got);
    chk("backpressure_ls", got, K_LS);
    do_txn(1, 0, 0, 32'h6000, 32'h0, 32'h0, 32'h7000, 4'h0, 32'h00004501, 1, 0, 0, 0, 0, 0, got);
    chk("c_fetch", {if_data, if_is_c, ls_done, pf_done}, {32'h00004501, 1'b1, 2'b00});
    do_txn(0, 1, 0, 32'h0, 32'h9000, 32'h1234, 32'h20, 4'b0001, 32'hbad0bad0, 0, 0, 0, 0, 1, 0, got);
    do_txn(1, 0, 0, 32'ha000, 32'h0, 32'h0, 32'hb000, 4'h0, 32'h0badc0de, 0, 0, 1, 5, 0, 0, got);
    chk("freeze_if", got, K_IF);
    for (int n = 0; n < 60; n++) begin
      {i, l, p} = 3'($urandom_range(1, 7));
      fl = $urandom_range(0, 11) == 0;
      do_txn(i, l, p, $urandom, $urandom, $urandom, $urandom, 4'($urandom), $urandom, 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 7) == 0 ? $urandom_range(2, 4) : 0,
             fl, !fl && $urandom_range(0, 1) == 1, got);
    end
    repeat (4) @(posedge clk_in);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1000000;
    errs++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end
endmodule
